// File: rtl/mul_div_unit_if.sv
// Request/response bundle between the multicycle control FSM (master)
// and the iterative multiply/divide unit (slave).
interface mul_div_unit_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic [1:0]       func;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] hi;
    logic             div_by_zero;

    modport master (
        output start, func, a, b,
        input  busy, done, lo, hi, div_by_zero
    );

    modport slave (
        input  start, func, a, b,
        output busy, done, lo, hi, div_by_zero
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative radix-2 multiply/divide unit, fixed latency for every func.
//   func: 00 umul, 01 smul, 10 udiv, 11 sdiv
//   lo -> w2_1 write-back (product low / quotient)
//   hi -> w2_2 write-back (product high / remainder)
// Signed ops run on magnitudes; signs are reapplied in the FIX state.
// Build option: define MUL_DIV_UNIT_DIV_EN to include the divider. Without
// it, divide funcs keep the handshake and latency but return zeros, and
// div_by_zero is tied low.
module mul_div_unit #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic           clk,
    input  logic           reset,
    mul_div_unit_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t                 state;
    logic [CNT_W-1:0]       cnt;
    logic                   is_div;
    logic                   neg_q;      // product / quotient negative
    logic [WIDTH-1:0]       opb;        // multiplicand or divisor magnitude
    logic [2*WIDTH-1:0]     acc;        // {hi half, lo half} working register
    logic                   busy_q;
    logic                   done_q;
    logic [WIDTH-1:0]       lo_q;
    logic [WIDTH-1:0]       hi_q;

    logic [WIDTH-1:0]       a_mag;
    logic [WIDTH-1:0]       b_mag;
    logic [WIDTH:0]         mul_sum;
    logic [2*WIDTH-1:0]     mul_next;
    logic [2*WIDTH-1:0]     step_next;
    logic [2*WIDTH-1:0]     prod_fix;

`ifdef MUL_DIV_UNIT_DIV_EN
    logic                   neg_r;      // remainder follows dividend sign
    logic                   b_zero;
    logic [WIDTH-1:0]       a_raw;      // returned unmodified on divide by zero
    logic                   dz_q;
    logic [WIDTH:0]         div_shift;
    logic [WIDTH:0]         div_diff;
    logic [2*WIDTH-1:0]     div_next;
    logic [WIDTH-1:0]       quo_fix;
    logic [WIDTH-1:0]       rem_fix;
`endif

    // Operand magnitudes for the signed funcs (0x8000 maps to 32768 unsigned).
    always_comb begin
        a_mag = bus.a;
        b_mag = bus.b;
        if (bus.func[0] && bus.a[WIDTH-1]) a_mag = -bus.a;
        if (bus.func[0] && bus.b[WIDTH-1]) b_mag = -bus.b;
    end

    // One shift-add multiply step: multiplier sits in acc low half and is
    // consumed LSB first while the partial product grows in from the top.
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
        mul_next = {mul_sum, acc[WIDTH-1:1]};
    end

`ifdef MUL_DIV_UNIT_DIV_EN
    // One restoring divide step: remainder in hi half, dividend bits shift
    // out of the lo half MSB first while quotient bits shift in at the LSB.
    always_comb begin
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opb};
        if (div_diff[WIDTH])
            div_next = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
        else
            div_next = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end

    // Select the active datapath step.
    always_comb begin
        step_next = is_div ? div_next : mul_next;
    end

    // Sign correction of quotient and remainder.
    always_comb begin
        quo_fix = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
        rem_fix = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
    end
`else
    // Only the multiplier exists; divide funcs just idle through RUN.
    always_comb begin
        step_next = mul_next;
    end
`endif

    // Sign correction of the full double-width product.
    always_comb begin
        prod_fix = neg_q ? -acc : acc;
    end

    // Control FSM plus datapath registers; all outputs are registered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            opb    <= '0;
            acc    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            lo_q   <= '0;
            hi_q   <= '0;
`ifdef MUL_DIV_UNIT_DIV_EN
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
            a_raw  <= '0;
            dz_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state  <= RUN;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        is_div <= bus.func[1];
                        neg_q  <= bus.func[0] & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
                        opb    <= b_mag;
                        acc    <= {{WIDTH{1'b0}}, a_mag};
`ifdef MUL_DIV_UNIT_DIV_EN
                        neg_r  <= bus.func[0] & bus.a[WIDTH-1];
                        b_zero <= (bus.b == '0);
                        a_raw  <= bus.a;
`endif
                    end
                end
                RUN: begin
                    acc <= step_next;
                    cnt <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH-1))
                        state <= FIX;
                end
                FIX: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
`ifdef MUL_DIV_UNIT_DIV_EN
                    if (is_div) begin
                        if (b_zero) begin
                            lo_q <= '1;
                            hi_q <= a_raw;
                            dz_q <= 1'b1;
                        end else begin
                            lo_q <= quo_fix;
                            hi_q <= rem_fix;
                            dz_q <= 1'b0;
                        end
                    end else begin
                        lo_q <= prod_fix[WIDTH-1:0];
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                        dz_q <= 1'b0;
                    end
`else
                    if (is_div) begin
                        lo_q <= '0;
                        hi_q <= '0;
                    end else begin
                        lo_q <= prod_fix[WIDTH-1:0];
                        hi_q <= prod_fix[2*WIDTH-1:WIDTH];
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.lo   = lo_q;
    assign bus.hi   = hi_q;
`ifdef MUL_DIV_UNIT_DIV_EN
    assign bus.div_by_zero = dz_q;
`else
    assign bus.div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_mul_div_unit.sv
// Bench for mul_div_unit: directed plan vectors, random ops against an
// arithmetic reference model, busy-start rejection, back-to-back issue and
// asynchronous reset mid-operation.
module tb_mul_div_unit;
    localparam int W   = 16;
    localparam int LAT = 17;   // negedges after the start edge until done
`ifdef MUL_DIV_UNIT_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;

    mul_div_unit_if #(.WIDTH(W)) bus();

    mul_div_unit #(.WIDTH(W), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the operand values.
    function automatic void model(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b,
                                  output logic [15:0] lo, output logic [15:0] hi, output logic dz);
        longint p;
        int sa, sb, q, r;
        dz = 1'b0;
        lo = '0;
        hi = '0;
        if (f == 2'b00) begin
            p  = longint'(a) * longint'(b);
            lo = p[15:0];
            hi = p[31:16];
        end else if (f == 2'b01) begin
            p  = longint'($signed(a)) * longint'($signed(b));
            lo = p[15:0];
            hi = p[31:16];
        end else if (DIV_EN) begin
            if (b == 16'd0) begin
                lo = 16'hFFFF;
                hi = a;
                dz = 1'b1;
            end else if (f == 2'b10) begin
                lo = a / b;
                hi = a % b;
            end else begin
                sa = int'($signed(a));
                sb = int'($signed(b));
                q  = sa / sb;
                r  = sa % sb;
                lo = q[15:0];
                hi = r[15:0];
            end
        end
    endfunction

    // Issue one op from a negedge and wait for done; lat = -1 on timeout.
    task automatic run_op(input logic [1:0] f, input logic [15:0] a, input logic [15:0] b,
                          output int lat, output logic [15:0] lo, output logic [15:0] hi,
                          output logic dz, output logic busy_bad);
        lat = -1;
        busy_bad = 1'b0;
        bus.start = 1'b1;
        bus.func  = f;
        bus.a     = a;
        bus.b     = b;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (bus.done) begin
                lat = n;
                if (bus.busy) busy_bad = 1'b1;
                break;
            end
            if (!bus.busy) busy_bad = 1'b1;
        end
        lo = bus.lo;
        hi = bus.hi;
        dz = bus.div_by_zero;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.func = 2'b00;
        bus.a = '0;
        bus.b = '0;
        #12;
        vectors++;
        if ({bus.busy, bus.done, bus.div_by_zero} !== 3'b000) begin
            $display("FAIL reset_flags got=%b want=000", {bus.busy, bus.done, bus.div_by_zero});
            miscompares++;
        end
        vectors++;
        if ({bus.hi, bus.lo} !== 32'h0) begin
            $display("FAIL reset_result got=%h want=00000000", {bus.hi, bus.lo});
            miscompares++;
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        logic [1:0]  tf[10] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b11};
        logic [15:0] ta[10] = '{16'hFFFF, 16'hFFFD, 16'h8000, 16'd100, 16'hFFF9, 16'h8000, 16'h1234, 16'd6, 16'd100, 16'hFFF9};
        logic [15:0] tb[10] = '{16'hFFFF, 16'h0007, 16'h8000, 16'd7, 16'd2, 16'hFFFF, 16'd0, 16'd3, 16'd0, 16'd0};
        logic [15:0] lo, hi, elo, ehi;
        logic dz, edz, bb;
        int lat;
        for (int i = 0; i < 10; i++) begin
            model(tf[i], ta[i], tb[i], elo, ehi, edz);
            run_op(tf[i], ta[i], tb[i], lat, lo, hi, dz, bb);
            vectors++;
            if (lat !== LAT) begin
                $display("FAIL dir%0d_latency got=%0d want=%0d", i, lat, LAT);
                miscompares++;
            end
            vectors++;
            if (bb !== 1'b0) begin
                $display("FAIL dir%0d_busy got=bad want=high_until_done", i);
                miscompares++;
            end
            vectors++;
            if ({hi, lo, dz} !== {ehi, elo, edz}) begin
                $display("FAIL dir%0d_result got=hi %h lo %h dz %b want=hi %h lo %h dz %b",
                         i, hi, lo, dz, ehi, elo, edz);
                miscompares++;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_random();
        logic [1:0]  f;
        logic [15:0] a, b, lo, hi, elo, ehi;
        logic dz, edz, bb;
        int lat;
        for (int i = 0; i < 60; i++) begin
            f = 2'($urandom_range(0, 3));
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
            if ($urandom_range(0, 9) == 0) a = 16'h8000;
            model(f, a, b, elo, ehi, edz);
            run_op(f, a, b, lat, lo, hi, dz, bb);
            vectors++;
            if (lat !== LAT || bb !== 1'b0) begin
                $display("FAIL rnd%0d_timing got=lat %0d busybad %b want=lat %0d busybad 0", i, lat, bb, LAT);
                miscompares++;
            end
            vectors++;
            if ({hi, lo, dz} !== {ehi, elo, edz}) begin
                $display("FAIL rnd%0d_result f=%b a=%h b=%h got=hi %h lo %h dz %b want=hi %h lo %h dz %b",
                         i, f, a, b, hi, lo, dz, ehi, elo, edz);
                miscompares++;
            end
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
    endtask

    // A start while busy is dropped; a start in the done cycle is taken.
    task automatic test_back_to_back();
        logic [15:0] lo, hi, elo, ehi;
        logic dz, edz, bb;
        int lat;
        lat = -1;
        bus.start = 1'b1;
        bus.func  = 2'b00;
        bus.a     = 16'd1234;
        bus.b     = 16'd5;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (n == 4) begin
                bus.start = 1'b1;
                bus.func  = 2'b01;
                bus.a     = 16'hFFFF;
                bus.b     = 16'h0007;
                @(posedge clk);
                #1 bus.start = 1'b0;
                bus.func = 2'b00;
                bus.a = 16'd1234;
                bus.b = 16'd5;
                continue;
            end
            if (bus.done) begin
                lat = n;
                break;
            end
        end
        model(2'b00, 16'd1234, 16'd5, elo, ehi, edz);
        vectors++;
        if (lat !== LAT) begin
            $display("FAIL ignore_latency got=%0d want=%0d", lat, LAT);
            miscompares++;
        end
        vectors++;
        if ({bus.hi, bus.lo, bus.div_by_zero} !== {ehi, elo, edz}) begin
            $display("FAIL ignore_result got=hi %h lo %h want=hi %h lo %h", bus.hi, bus.lo, ehi, elo);
            miscompares++;
        end
        // Still in the done cycle: issue the next op immediately.
        model(2'b11, 16'hFFF9, 16'd2, elo, ehi, edz);
        run_op(2'b11, 16'hFFF9, 16'd2, lat, lo, hi, dz, bb);
        vectors++;
        if (lat !== LAT || bb !== 1'b0) begin
            $display("FAIL b2b_timing got=lat %0d busybad %b want=lat %0d busybad 0", lat, bb, LAT);
            miscompares++;
        end
        vectors++;
        if ({hi, lo, dz} !== {ehi, elo, edz}) begin
            $display("FAIL b2b_result got=hi %h lo %h dz %b want=hi %h lo %h dz %b", hi, lo, dz, ehi, elo, edz);
            miscompares++;
        end
        @(negedge clk);
    endtask

    task automatic test_async_reset();
        logic [15:0] lo, hi, elo, ehi;
        logic dz, edz, bb;
        int lat;
        int seen;
        run_op(2'b00, 16'd300, 16'd700, lat, lo, hi, dz, bb);   // leaves lo/hi non-zero
        @(negedge clk);
        bus.start = 1'b1;
        bus.func  = 2'b01;
        bus.a     = 16'hABCD;
        bus.b     = 16'h1357;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (6) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({bus.busy, bus.done, bus.div_by_zero, bus.hi, bus.lo} !== 35'h0) begin
            $display("FAIL async_reset got=busy %b done %b hi %h lo %h want=all zero",
                     bus.busy, bus.done, bus.hi, bus.lo);
            miscompares++;
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(negedge clk);
            if (bus.done || bus.busy) seen++;
        end
        vectors++;
        if (seen !== 0) begin
            $display("FAIL post_reset_quiet got=%0d active cycles want=0", seen);
            miscompares++;
        end
        model(2'b01, 16'hFFFD, 16'h0007, elo, ehi, edz);
        run_op(2'b01, 16'hFFFD, 16'h0007, lat, lo, hi, dz, bb);
        vectors++;
        if (lat !== LAT || {hi, lo, dz} !== {ehi, elo, edz}) begin
            $display("FAIL post_reset_op got=lat %0d hi %h lo %h want=lat %0d hi %h lo %h",
                     lat, hi, lo, LAT, ehi, elo);
            miscompares++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
